// File: rtl/vga_rx_capture_if.sv
// Purpose: bundles the VGA pin inputs and the qualified pixel stream of vga_rx_capture.
// Latency: none, wiring only.
// Backpressure: none; the pixel stream is free-running at the pixel clock.
interface vga_rx_capture_if;
    // VGA side, driven by the screen core (or a stimulus source)
    logic       en;
    logic       hsync;
    logic       vsync;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;

    // Recovered pixel stream and status
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [11:0] pix_rgb;
    logic       frame_start;
    logic       frame_done;
    logic       lock;
    logic       err_line;
    logic       err_frame;

    // Source of the VGA pins and consumer of the pixel stream
    modport master (
        output en, hsync, vsync, R, G, B,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done,
               lock, err_line, err_frame
    );

    // The capture block itself
    modport slave (
        input  en, hsync, vsync, R, G, B,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done,
               lock, err_line, err_frame
    );
endinterface

// File: rtl/vga_rx_capture.sv
// Purpose: recovers x/y from VGA syncs, checks raster timing, emits a qualified pixel stream once locked.
// Latency: RGB on the pins appears on pix_rgb two clocks later, with matching x/y/valid/markers.
// Backpressure: none; the stream cannot be stalled, pix_valid simply qualifies each clock.
module vga_rx_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    vga_rx_capture_if.slave vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_LO = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_HI = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic {
        SEEK  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Input stage: stage 1 holds the pixel being decoded, stage 2 only feeds edge detect
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;
    logic [11:0] rgb1_q, rgb1_d;

    // Raster position of the pixel currently in stage 1 is h_cnt_d / v_cnt_d
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        vs_pend_q, vs_pend_d;

    // Registered pixel stream
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;

    // Lock FSM state and its registered outputs
    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        lock_q, lock_d;
    logic        err_line_q, err_line_d;
    logic        err_frame_q, err_frame_d;

    // Decoded events
    logic        hs_edge;
    logic        vs_edge;
    logic        vs_consume;
    logic        line_bad;
    logic        frame_bad;
    logic        h_act;
    logic        v_act;
    logic [9:0]  x_now;
    logic [9:0]  y_now;

    // Sync assert edges: stage 1 now at the asserted level, stage 2 was not
    assign hs_edge    = (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
    assign vs_edge    = (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);
    // A vsync edge arriving with the hsync edge is consumed on the spot
    assign vs_consume = hs_edge && (vs_pend_q || vs_edge);

    // Length checks look at the count of the last clock of the line/frame just ended
    assign line_bad  = hs_edge && (h_cnt_q != H_LAST);
    assign frame_bad = vs_consume && (v_cnt_q != V_LAST);

    // Input registers and edge-detect history
    always_comb begin
        hs1_d  = vif.hsync;
        vs1_d  = vif.vsync;
        rgb1_d = {vif.R, vif.G, vif.B};
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
    end

    // Saturating raster counters and the pending-vsync flag
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        vs_pend_d = vs_pend_q;

        if (hs_edge) begin
            h_cnt_d = 12'd0;
        end else if (h_cnt_q != 12'hFFF) begin
            h_cnt_d = h_cnt_q + 12'd1;
        end

        if (hs_edge) begin
            if (vs_consume) begin
                v_cnt_d = 11'd0;
            end else if (v_cnt_q != 11'h7FF) begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end

        if (hs_edge) begin
            vs_pend_d = 1'b0;
        end else if (vs_edge) begin
            vs_pend_d = 1'b1;
        end
    end

    // Active-window decode and the next pixel-stream word; x/y/rgb hold while invalid
    always_comb begin
        h_act = (h_cnt_d >= H_ACT_LO) && (h_cnt_d <= H_ACT_HI);
        v_act = (v_cnt_d >= V_ACT_LO) && (v_cnt_d <= V_ACT_HI);
        x_now = 10'(h_cnt_d - H_ACT_LO);
        y_now = 10'(v_cnt_d - V_ACT_LO);

        pix_valid_d   = h_act && v_act && lock_q && vif.en && (state_q == TRACK);
        pix_x_d       = pix_valid_d ? x_now  : pix_x_q;
        pix_y_d       = pix_valid_d ? y_now  : pix_y_q;
        pix_rgb_d     = pix_valid_d ? rgb1_q : pix_rgb_q;
        frame_start_d = pix_valid_d && (x_now == 10'd0) && (y_now == 10'd0);
        frame_done_d  = pix_valid_d && (x_now == X_LAST) && (y_now == Y_LAST);
    end

    // Lock tracking: enter TRACK at a vsync, count good frames, drop out on any length error
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        lock_d      = lock_q;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;

        if (!vif.en) begin
            state_d    = SEEK;
            good_cnt_d = 4'd0;
            lock_d     = 1'b0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (vs_consume) begin
                        state_d    = TRACK;
                        good_cnt_d = 4'd0;
                    end
                end
                TRACK: begin
                    if (line_bad || frame_bad) begin
                        err_line_d  = line_bad;
                        err_frame_d = frame_bad;
                        state_d     = SEEK;
                        good_cnt_d  = 4'd0;
                        lock_d      = 1'b0;
                    end else if (vs_consume) begin
                        if (good_cnt_q != 4'hF) begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                        if (good_cnt_d >= LOCK_N) begin
                            lock_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = SEEK;
                end
            endcase
        end
    end

    // Datapath registers: input stage, counters and pixel-stream outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            rgb1_q        <= 12'd0;
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 11'd0;
            vs_pend_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_rgb_q     <= 12'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            rgb1_q        <= rgb1_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_pend_q     <= vs_pend_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Lock FSM registers, including its registered lock/error outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SEEK;
            good_cnt_q  <= 4'd0;
            lock_q      <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            lock_q      <= lock_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign vif.pix_valid   = pix_valid_q;
    assign vif.pix_x       = pix_x_q;
    assign vif.pix_y       = pix_y_q;
    assign vif.pix_rgb     = pix_rgb_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_done  = frame_done_q;
    assign vif.lock        = lock_q;
    assign vif.err_line    = err_line_q;
    assign vif.err_frame   = err_frame_q;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Purpose: randomized raster stimulus with a frame/line-level lock model and a pixel scoreboard.
// Latency: expects each active pin pixel two clocks later on the pixel stream.
// Backpressure: none; the monitor consumes every valid pixel as it appears.
module tb_vga_rx_capture;

    // Small raster so many frames fit in a short run
    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LOCKN  = 2;
    localparam int EN_LEN = 10;
    localparam bit POL    = 1'b0;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        fs;
        logic        fd;
    } pix_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vga_rx_capture_if vif ();

    vga_rx_capture #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .vif   (vif)
    );

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   exp_el = 0, exp_ef = 0, exp_both = 0;
    int   obs_el = 0, obs_ef = 0, obs_both = 0;

    // Reference model: lock state kept in terms of whole lines and frames
    bit   m_track;
    bit   m_lock;
    int   m_good;
    int   g_line_len;
    int   g_frame_lines;
    bit   pend_act;
    pix_t pend_pix;

    task automatic check(input bit ok, input string name,
                         input longint unsigned got, input longint unsigned want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        check(vif.pix_valid == 1'b0,    {tag, "_pix_valid"},   64'(vif.pix_valid),   0);
        check(vif.pix_x == 10'd0,       {tag, "_pix_x"},       64'(vif.pix_x),       0);
        check(vif.pix_y == 10'd0,       {tag, "_pix_y"},       64'(vif.pix_y),       0);
        check(vif.pix_rgb == 12'd0,     {tag, "_pix_rgb"},     64'(vif.pix_rgb),     0);
        check(vif.frame_start == 1'b0,  {tag, "_frame_start"}, 64'(vif.frame_start), 0);
        check(vif.frame_done == 1'b0,   {tag, "_frame_done"},  64'(vif.frame_done),  0);
        check(vif.lock == 1'b0,         {tag, "_lock"},        64'(vif.lock),        0);
        check(vif.err_line == 1'b0,     {tag, "_err_line"},    64'(vif.err_line),    0);
        check(vif.err_frame == 1'b0,    {tag, "_err_frame"},   64'(vif.err_frame),   0);
    endtask

    task automatic model_clear();
        m_track = 1'b0;
        m_good  = 0;
        m_lock  = 1'b0;
    endtask

    // A line (and possibly a frame) begins: judge the line/frame that just ended
    task automatic model_line_start(input bit fr_start);
        bit el;
        bit ef;
        el = m_track && (g_line_len != HT);
        ef = m_track && fr_start && (g_frame_lines != VT);
        if (el || ef) begin
            if (el) exp_el++;
            if (ef) exp_ef++;
            if (el && ef) exp_both++;
            model_clear();
        end else if (fr_start) begin
            if (!m_track) begin
                m_track = 1'b1;
                m_good  = 0;
            end else begin
                if (m_good < 15) m_good++;
                if (m_good >= LOCKN) m_lock = 1'b1;
            end
        end
        g_line_len = 0;
        if (fr_start) g_frame_lines = 0;
        g_frame_lines++;
    endtask

    // One pixel clock of stimulus; rst_op: 1 = assert reset, 2 = release reset
    task automatic drive_slot(input bit hs_a, input bit vs_a, input logic [11:0] rgb,
                              input bit act, input int x, input int y,
                              input bit ln_start, input bit fr_start, input bit en_v,
                              input bit chk_lock, input int rst_op);
        @(posedge clk);
        #1;
        vif.hsync = hs_a ? POL : ~POL;
        vif.vsync = vs_a ? POL : ~POL;
        vif.R     = rgb[11:8];
        vif.G     = rgb[7:4];
        vif.B     = rgb[3:0];
        vif.en    = en_v;
        if (rst_op == 1) begin
            resetn = 1'b0;
            #1;
            chk_outputs_zero("midline_reset");
            model_clear();
            pend_act = 1'b0;
        end else if (rst_op == 2) begin
            resetn = 1'b1;
        end
        if (chk_lock) begin
            @(negedge clk);
            check(vif.lock == m_lock, "lock_state", 64'(vif.lock), 64'(m_lock));
        end
        // The previous slot's pixel is qualified by this slot's enable
        if (pend_act && en_v && m_lock) begin
            exp_q.push_back(pend_pix);
            n_push++;
        end
        if (!en_v) model_clear();
        if (ln_start && en_v) model_line_start(fr_start);
        else if (ln_start) begin
            g_line_len = 0;
            if (fr_start) g_frame_lines = 0;
            g_frame_lines++;
        end
        g_line_len++;
        pend_act = act;
        pend_pix = '{x: 10'(x), y: 10'(y), rgb: rgb,
                     fs: act && (x == 0) && (y == 0),
                     fd: act && (x == HA - 1) && (y == VA - 1)};
    endtask

    task automatic run_frame(input int n_lines, input int short_line,
                             input int en_line, input int rst_line);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                bit          act;
                bit          en_v;
                int          x;
                int          y;
                int          rop;
                logic [11:0] rgb;
                x    = h - (HS + HB);
                y    = l - (VS + VB);
                act  = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
                rgb  = (act && x == 0 && y == 0) ? 12'hFF0 : 12'($urandom);
                en_v = !((l == en_line) && (h >= HS + HB + 3) && (h < HS + HB + 3 + EN_LEN));
                rop  = (l == rst_line && h == 2) ? 1 : ((l == rst_line && h == 5) ? 2 : 0);
                drive_slot(h < HS, l < VS, rgb, act, x, y, h == 0, (h == 0) && (l == 0),
                           en_v, h == HT / 2, rop);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel, counts error pulses
    initial begin
        pix_t got;
        pix_t want;
        forever begin
            @(negedge clk);
            if (vif.err_line === 1'b1) obs_el++;
            if (vif.err_frame === 1'b1) obs_ef++;
            if (vif.err_line === 1'b1 && vif.err_frame === 1'b1) obs_both++;
            if (vif.pix_valid === 1'b1) begin
                got = '{x: vif.pix_x, y: vif.pix_y, rgb: vif.pix_rgb,
                        fs: vif.frame_start, fd: vif.frame_done};
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_pixel", 64'(got), 0);
                end else begin
                    want = exp_q.pop_front();
                    n_pop++;
                    check(got == want, "pixel", 64'(got), 64'(want));
                end
            end else if (vif.frame_start === 1'b1 || vif.frame_done === 1'b1) begin
                check(1'b0, "marker_without_valid",
                      64'({vif.frame_start, vif.frame_done}), 0);
            end
        end
    end

    initial begin
        int sl;
        int el;
        vif.en    = 1'b1;
        vif.hsync = ~POL;
        vif.vsync = ~POL;
        vif.R     = 4'd0;
        vif.G     = 4'd0;
        vif.B     = 4'd0;
        resetn    = 1'b0;
        model_clear();
        g_line_len    = 0;
        g_frame_lines = 0;
        pend_act      = 1'b0;
        pend_pix      = '0;

        repeat (7) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        resetn = 1'b1;
        repeat (2) drive_slot(1'b0, 1'b0, 12'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Clean raster: lock after two good frames
        repeat (4) run_frame(VT, -1, -1, -1);

        // One shortened line, then relock
        sl = $urandom_range(VT - 1, 1);
        run_frame(VT, sl, -1, -1);
        repeat (5) run_frame(VT, -1, -1, -1);

        // One frame a line short, then relock
        run_frame(VT - 1, -1, -1, -1);
        repeat (5) run_frame(VT, -1, -1, -1);

        // Short frame whose last line is also short: both errors at once
        run_frame(VT - 1, VT - 2, -1, -1);
        repeat (5) run_frame(VT, -1, -1, -1);

        // Enable dropped inside an active line
        el = $urandom_range(VS + VB + VA - 1, VS + VB);
        run_frame(VT, -1, el, -1);
        repeat (4) run_frame(VT, -1, -1, -1);

        // Asynchronous reset in the middle of a line while locked
        run_frame(VT, -1, -1, VS + VB + 3);
        repeat (4) run_frame(VT, -1, -1, -1);

        repeat (5) drive_slot(1'b0, 1'b0, 12'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);

        check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 0);
        check(n_pop == n_push, "pixel_count", 64'(n_pop), 64'(n_push));
        check(obs_el == exp_el, "err_line_count", 64'(obs_el), 64'(exp_el));
        check(obs_ef == exp_ef, "err_frame_count", 64'(obs_ef), 64'(exp_ef));
        check(obs_both == exp_both, "err_both_count", 64'(obs_both), 64'(exp_both));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rx_capture.md
Name: vga_rx_capture

Overview:
- Receiving end of the debug-screen VGA link: samples hsync/vsync/R/G/B produced by the debug screen core on the same pixel clock.
- Recovers pixel coordinates, checks raster timing against the configured mode, and emits a qualified pixel stream (valid, x, y, 12-bit colour) once locked.
- Sits between the VGA output pins and any frame-buffer/checker logic, for in-system readback and self-test of the screen core.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync pulse width clocks
- H_BP, 48, horizontal back porch clocks (H_TOTAL = sum = 800)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BP, 33, vertical back porch lines (V_TOTAL = sum = 525)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  capture enable
- hsync  in  1  horizontal sync from the screen core
- vsync  in  1  vertical sync from the screen core
- R  in  4  red
- G  in  4  green
- B  in  4  blue
- pix_valid  out  1  active pixel qualifier
- pix_x  out  10  column 0..H_ACTIVE-1
- pix_y  out  10  row 0..V_ACTIVE-1
- pix_rgb  out  12  {R,G,B} of the pixel
- frame_start  out  1  pulse with pixel (0,0)
- frame_done  out  1  pulse with pixel (H_ACTIVE-1,V_ACTIVE-1)
- lock  out  1  timing locked
- err_line  out  1  one-cycle pulse on bad line length
- err_frame  out  1  one-cycle pulse on bad frame length

Behaviour:
- Reset (async, resetn=0): all outputs 0, FSM=SEEK, all counters and input registers 0, vs_pend=0.
- Input stage:
  - hsync/vsync/RGB registered once (stage 1).
  - A second register on the syncs is used for edge detection.
  - Assert edge = stage-1 value == SYNC_POL and previous value != SYNC_POL.
- h_cnt (12 bit):
  - Loaded to 0 on an hsync assert edge, else incremented.
  - Saturates at 4095.
  - h_cnt=0 is the first sync clock.
- vs_pend: set on a vsync assert edge; cleared when consumed at the next hsync assert edge. A coincident vsync and hsync edge is consumed immediately.
- v_cnt (11 bit), updated only on hsync assert edges:
  - 0 if vsync is consumed on that edge, else +1.
  - Saturates at 2047.
- Active window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - pix_x = h_cnt-(H_SYNC+H_BP)
  - pix_y = v_cnt-(V_SYNC+V_BP)
- Output stage:
  - pix_valid = active & lock & en & state==TRACK.
  - All outputs are registered. RGB present on the pins at clock t appears on pix_rgb at t+2, with its matching x/y/valid.
  - pix_x, pix_y, pix_rgb hold their last value when pix_valid=0.
- FSM:
  - SEEK: counters run, no error checks. First vsync consume -> TRACK, good_cnt=0.
  - TRACK, every hsync edge: if h_cnt != H_TOTAL-1, pulse err_line, clear lock and good_cnt, go to SEEK.
  - TRACK, every vsync consume:
    - If v_cnt != V_TOTAL-1: pulse err_frame, clear lock and good_cnt, go to SEEK.
    - Else good_cnt++ (saturating). When good_cnt reaches LOCK_FRAMES, set lock.
  - Simultaneous line and frame error: both pulses asserted in the same cycle.
- en=0: FSM forced to SEEK, lock=0, good_cnt=0, pix_valid=0. Counters keep tracking. No error pulses.
- Sync absent (no edges): counters saturate. No errors are flagged until the next edge, which then fails its length check.
- frame_start and frame_done are asserted only together with pix_valid=1.

Test Plan:
- Reset held 7 clocks, then a clean 800x525 raster with active-low syncs -> lock=0 through frame 1. lock=1 one clock after the 2nd good frame's vsync consume. No err pulses.
- Locked, pin RGB = 12'hFF0 on row 0 col 0 -> two cycles later: pix_valid=1, pix_x=0, pix_y=0, pix_rgb=12'hFF0, frame_start=1. Exactly 640x480 valid cycles per frame, frame_done with (639,479).
- Locked, one line shortened to 799 clocks -> err_line pulses once, lock=0, pix_valid stays 0. Relock after 2 good frames.
- Locked, frame with 524 lines -> err_frame pulses at vsync consume, lock=0, FSM=SEEK.
- en dropped mid-frame for 100 clocks -> pix_valid=0 and lock=0 immediately, no err pulses. Relock 2 good frames after en returns.
- resetn pulsed low mid-line while locked -> all outputs 0 asynchronously. Normal relock sequence follows after release.
